// File: rtl/i2c_reg_seq.sv
// I2C register-access sequencer: turns one register read/write command into the
// byte-level handshake with an I2C master and buffers the bytes read back.
module i2c_reg_seq #(
   parameter logic [6:0]  DEV_ADR = 7'h77,
   parameter int unsigned MAX_LEN = 22,
   parameter int unsigned LW      = 5,
   parameter int unsigned TIMEOUT = 16'hFFFF
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cmd_valid,
   input  logic          cmd_write,
   input  logic [7:0]    cmd_reg,
   input  logic [LW-1:0] cmd_len,
   input  logic [7:0]    wr_data,
   output logic          busy,
   output logic          done,
   output logic          err,
   input  logic [LW-1:0] rd_idx,
   output logic [7:0]    rd_data,
   input  logic          isReady,
   output logic          start,
   output logic [7:0]    datasend,
   output logic          send,
   input  logic          sended,
   input  logic          nack,
   output logic          receive,
   output logic          last_rx,
   input  logic [7:0]    datareceive,
   input  logic          received,
   output logic          stop
);
   typedef enum logic [3:0] {
      ST_IDLE, ST_WAIT_RDY, ST_LOAD, ST_SEND, ST_WAIT_SENT,
      ST_RECV, ST_WAIT_RCV, ST_FINISH, ST_ERR
   } state_t;

   localparam logic [15:0]   TMO_LIM   = 16'(TIMEOUT);
   localparam logic [LW-1:0] MAX_LEN_L = LW'(MAX_LEN);

   state_t        state_q, state_d;
   logic [1:0]    tx_idx_q, tx_idx_d;
   logic [LW-1:0] rx_idx_q, rx_idx_d, len_q, len_d;
   logic          write_q, write_d, bus_act_q, bus_act_d;
   logic [7:0]    reg_q, reg_d, wdat_q, wdat_d;
   logic [15:0]   tmo_q, tmo_d;
   logic          sended_prev_q, sended_prev_d, received_prev_q, received_prev_d;
   logic          busy_q, busy_d, done_q, done_d, err_q, err_d, stop_q, stop_d;
   logic          start_q, start_d, send_q, send_d, receive_q, receive_d, last_rx_q, last_rx_d;
   logic [7:0]    datasend_q, datasend_d;
   logic [7:0]    rx_buf_q [MAX_LEN];
   logic [7:0]    rx_buf_d [MAX_LEN];
   logic          sended_rise_s, received_rise_s, last_byte_s;

   // Byte list: {start flag, byte} for transmit slot idx.
   function automatic logic [8:0] tx_byte(input logic [1:0] idx, input logic wr,
                                          input logic [7:0] rg, input logic [7:0] wd);
      logic [8:0] b;
      case (idx)
         2'd0:    b = {1'b1, DEV_ADR, 1'b0};
         2'd1:    b = {1'b0, rg};
         2'd2:    b = wr ? {1'b0, wd} : {1'b1, DEV_ADR, 1'b1};
         default: b = 9'h000;
      endcase
      return b;
   endfunction

   assign sended_rise_s   = sended & ~sended_prev_q;
   assign received_rise_s = received & ~received_prev_q;
   assign last_byte_s     = (rx_idx_q == (len_q - LW'(1)));

   // Next-state, handshake outputs and buffer capture.
   always_comb begin
      state_d = state_q;          tx_idx_d = tx_idx_q;     rx_idx_d = rx_idx_q;
      len_d = len_q;              write_d = write_q;       reg_d = reg_q;
      wdat_d = wdat_q;            bus_act_d = bus_act_q;   busy_d = busy_q;
      done_d = 1'b0;              err_d = 1'b0;            stop_d = 1'b0;
      start_d = start_q;          datasend_d = datasend_q; send_d = send_q;
      receive_d = receive_q;      last_rx_d = last_rx_q;   rx_buf_d = rx_buf_q;
      sended_prev_d = sended;     received_prev_d = received;
      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               if (!cmd_write && ((cmd_len == '0) || (cmd_len > MAX_LEN_L))) begin
                  err_d = 1'b1;
               end else begin
                  state_d = ST_WAIT_RDY;  busy_d = 1'b1;    bus_act_d = 1'b0;
                  tx_idx_d = 2'd0;        rx_idx_d = '0;    len_d = cmd_len;
                  write_d = cmd_write;    reg_d = cmd_reg;  wdat_d = wr_data;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WAIT_RDY: begin
            if (isReady) begin
               state_d = ST_LOAD;
               bus_act_d = 1'b1;
               {start_d, datasend_d} = tx_byte(tx_idx_q, write_q, reg_q, wdat_q);
            end else if (tmo_q == TMO_LIM) begin
               state_d = ST_ERR;
            end else begin
               state_d = ST_WAIT_RDY;
            end
         end
         ST_LOAD: begin
            state_d = ST_SEND;
            send_d = 1'b1;
         end
         // The sent strobe is honoured in SEND too so a fast master is never missed.
         ST_SEND, ST_WAIT_SENT: begin
            if (sended_rise_s) begin
               send_d = 1'b0;
               if (nack) begin
                  state_d = ST_ERR;
               end else if (tx_idx_q == 2'd2) begin
                  state_d = write_q ? ST_FINISH : ST_RECV;
               end else begin
                  state_d = ST_LOAD;
                  tx_idx_d = tx_idx_q + 2'd1;
                  {start_d, datasend_d} = tx_byte(tx_idx_q + 2'd1, write_q, reg_q, wdat_q);
               end
            end else if ((state_q == ST_WAIT_SENT) && (tmo_q == TMO_LIM)) begin
               state_d = ST_ERR;
               send_d = 1'b0;
            end else begin
               state_d = ST_WAIT_SENT;
            end
         end
         ST_RECV: begin
            state_d = ST_WAIT_RCV;
            receive_d = 1'b1;
            last_rx_d = last_byte_s;
         end
         ST_WAIT_RCV: begin
            if (received_rise_s) begin
               if (rx_idx_q < MAX_LEN_L) begin
                  rx_buf_d[rx_idx_q] = datareceive;
               end else begin
                  rx_buf_d = rx_buf_q;
               end
               rx_idx_d = rx_idx_q + LW'(1);
               receive_d = 1'b0;
               last_rx_d = 1'b0;
               state_d = last_byte_s ? ST_FINISH : ST_RECV;
            end else if (tmo_q == TMO_LIM) begin
               state_d = ST_ERR;
               receive_d = 1'b0;
               last_rx_d = 1'b0;
            end else begin
               state_d = ST_WAIT_RCV;
            end
         end
         ST_FINISH: begin
            state_d = ST_IDLE;
            done_d = 1'b1;
            stop_d = 1'b1;
            busy_d = 1'b0;
         end
         ST_ERR: begin
            state_d = ST_IDLE;
            err_d = 1'b1;
            stop_d = bus_act_q;
            busy_d = 1'b0;
            send_d = 1'b0;
            receive_d = 1'b0;
            last_rx_d = 1'b0;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      if (state_d != state_q) begin
         tmo_d = 16'h0000;
      end else if ((state_q == ST_WAIT_RDY) || (state_q == ST_WAIT_SENT) || (state_q == ST_WAIT_RCV)) begin
         tmo_d = tmo_q + 16'h0001;
      end else begin
         tmo_d = 16'h0000;
      end
   end

   // State, output and buffer registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;   tx_idx_q <= 2'd0;      rx_idx_q <= '0;         len_q <= '0;
         write_q <= 1'b0;      reg_q <= 8'h00;        wdat_q <= 8'h00;        bus_act_q <= 1'b0;
         tmo_q <= 16'h0000;    sended_prev_q <= 1'b0; received_prev_q <= 1'b0;
         busy_q <= 1'b0;       done_q <= 1'b0;        err_q <= 1'b0;          stop_q <= 1'b0;
         start_q <= 1'b0;      datasend_q <= 8'h00;   send_q <= 1'b0;
         receive_q <= 1'b0;    last_rx_q <= 1'b0;
         for (int i = 0; i < MAX_LEN; i++) rx_buf_q[i] <= 8'h00;
      end else begin
         state_q <= state_d;   tx_idx_q <= tx_idx_d;  rx_idx_q <= rx_idx_d;   len_q <= len_d;
         write_q <= write_d;   reg_q <= reg_d;        wdat_q <= wdat_d;       bus_act_q <= bus_act_d;
         tmo_q <= tmo_d;       sended_prev_q <= sended_prev_d; received_prev_q <= received_prev_d;
         busy_q <= busy_d;     done_q <= done_d;      err_q <= err_d;         stop_q <= stop_d;
         start_q <= start_d;   datasend_q <= datasend_d; send_q <= send_d;
         receive_q <= receive_d; last_rx_q <= last_rx_d;
         rx_buf_q <= rx_buf_d;
      end
   end

   // Indexed buffer read port.
   always_comb begin
      if (rd_idx < MAX_LEN_L) begin
         rd_data = rx_buf_q[rd_idx];
      end else begin
         rd_data = 8'h00;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign err      = err_q;
   assign stop     = stop_q;
   assign start    = start_q;
   assign datasend = datasend_q;
   assign send     = send_q;
   assign receive  = receive_q;
   assign last_rx  = last_rx_q;
endmodule

// File: doc/i2c_reg_seq.md
# i2c_reg_seq

Parametrised I2C register-access sequencer, the generic successor to the per-sensor BMP180 controller. It sits between the user logic and the byte-level I2C master. It turns a single command (device register, read or write, burst length) into the full byte handshake sequence: address, register, optional repeated start, then data. Read bytes land in an internal buffer exposed through an indexed read port, so one block serves the BMP180 ID, calibration, temperature and pressure transactions.

## Interface
- `DEV_ADR`, default 7'h77: 7-bit I2C device address.
- `MAX_LEN`, default 22: buffer depth in bytes; also the largest legal burst.
- `LW`, default 5: width of `cmd_len` and `rd_idx`; must satisfy 2^LW > MAX_LEN.
- `TIMEOUT`, default 16'hFFFF: cycles to wait for any master handshake edge before aborting.
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: start a transaction; sampled only in IDLE.
- `cmd_write` in 1: 1 = write one byte `wr_data`; 0 = burst read.
- `cmd_reg` in 8: target register address.
- `cmd_len` in LW: read length, 1..MAX_LEN; ignored for writes.
- `wr_data` in 8: byte written in write mode.
- `busy` out 1: transaction in progress.
- `done` out 1: one-cycle pulse on success.
- `err` out 1: one-cycle pulse on reject, NACK or timeout.
- `rd_idx` in LW: buffer read index.
- `rd_data` out 8: combinational `buf[rd_idx]`; 8'h00 when rd_idx ≥ MAX_LEN.
- `isReady` in 1: master idle.
- `start` out 1: current byte is preceded by START or repeated START.
- `datasend` out 8: byte to transmit.
- `send` out 1: request the master to transmit `datasend`.
- `sended` in 1: master byte-sent strobe.
- `nack` in 1: slave NACKed the byte; valid while `sended` is high.
- `receive` out 1: request the master to receive a byte.
- `last_rx` out 1: the byte being received is the final one; the master must NACK it.
- `datareceive` in 8: received byte.
- `received` in 1: master byte-received strobe.
- `stop` out 1: one-cycle pulse; the master issues STOP.

## Operation
- Reset values: busy, done, err, start, send, receive, last_rx and stop are 0; datasend is 8'h00; all buffer bytes are 8'h00; state is IDLE.
- States and transitions:
  - IDLE → WAIT_RDY on an accepted command.
  - WAIT_RDY → LOAD once isReady=1.
  - LOAD → SEND → WAIT_SENT for each transmitted byte.
  - After the last transmitted byte: write mode goes to FINISH; read mode goes to RECV → WAIT_RCV for each received byte.
  - FINISH → IDLE.
  - ERR → IDLE.
- Command accept: in IDLE with cmd_valid=1.
  - Read with cmd_len=0 or cmd_len>MAX_LEN is rejected: err pulses one cycle later, there is no bus activity and busy stays 0.
  - Otherwise the block latches cmd_reg, cmd_len, cmd_write and wr_data, and busy=1 from the next cycle.
- Write byte list: {start=1, DEV_ADR,0}, {0, cmd_reg}, {0, wr_data}.
- Read byte list: {1, DEV_ADR,0}, {0, cmd_reg}, {1, DEV_ADR,1}, then cmd_len receive slots.
- Transmit, per byte:
  - LOAD drives datasend and start.
  - SEND raises send.
  - WAIT_SENT holds send=1 and stable datasend/start until a rising edge of sended, detected by comparing it with a registered previous value.
  - On that edge with nack=1, go to ERR. Otherwise drop send and advance.
- Receive:
  - receive=1 in WAIT_RCV; last_rx=1 when the byte index = cmd_len−1.
  - On a rising edge of received, write datareceive into buf[index] and increment the index.
  - After the last byte, drop receive and go to FINISH.
  - Byte capture is synchronous to clk; `received` is never used as a clock.
- FINISH: stop=1 and done=1 for one cycle; busy=0 from the following cycle.
- ERR: entered on NACK or on the timeout counter reaching TIMEOUT in WAIT_RDY, WAIT_SENT or WAIT_RCV. The timeout counter clears on every state change.
  - ERR drops send and receive, and pulses stop (except from WAIT_RDY) and err for one cycle.
  - Buffer bytes already captured are kept; later bytes are untouched.
- Buffer persistence: contents persist across transactions and are overwritten only at the indices received.
- cmd_valid while busy=1 is ignored.
- done and err never assert in the same cycle.

## Timing
- Cycle 0: command sampled. Cycle 1: busy=1 and state WAIT_RDY.
- isReady=1 at cycle n: LOAD at n+1, send=1 at n+2.
- Rising edge of sended seen at cycle m: send=0 at m+1; the next byte's datasend/start are valid at m+1 and its send=1 at m+2. send is therefore low for at least one cycle between bytes.
- A sended level held high for multiple cycles counts once. A held received level counts once.
- Last received edge at cycle r: buffer written at r+1, receive=0 at r+1, done/stop at r+2.
- Asynchronous reset mid-transaction: all outputs and the buffer return to reset values immediately; no stop is issued.

## Test plan
- Read ID: cmd_reg=8'hD0, len=1.
  - Required bytes: EE (start=1), D0, EF (start=1); then one receive with last_rx=1.
  - Master returns 8'h55 → rd_data[0]=8'h55, a single done pulse and a stop pulse.
- Calibration burst: cmd_reg=8'hAA, len=22 with ramp data 8'h00..8'h15.
  - Required: buf[i]=i; last_rx high only for i=21; rd_idx=22 reads 8'h00.
- Write: cmd_reg=8'hF4, wr_data=8'h2E.
  - Required bytes: EE, F4, 2E; receive never asserted; done after the third sended edge.
- Errors, each giving err=1 and no done:
  - nack=1 on the second sended edge → ERR with stop.
  - sended silent for TIMEOUT cycles (with TIMEOUT=16 in the bench) → err.
  - Read with len=0 → err with no send.
- Robustness:
  - sended and received held high 5 cycles → counted once each.
  - cmd_valid while busy → ignored.
  - reset asserted during a receive → all outputs 0 and buffer cleared within the same cycle.
